// File: rtl/scon_bank_if.sv
// CPU register-bus interface for scon_bank: write strobe/address/data plus
// read address and registered read data.
interface scon_bank_if #(
  parameter int unsigned AW = 2
) ();
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr,
    input  rd_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr,
    output rd_data
  );
endinterface

// File: rtl/scon_bank.sv
// Multi-channel 8051-style SCON register bank with SM2 address filtering and
// lowest-channel-first interrupt aggregation. Define SCON_OVERRUN_EN to build overrun flags.
module scon_bank #(
  parameter int unsigned NCH      = 4,
  parameter int unsigned AW       = 2,
  parameter logic [7:0]  RST_SCON = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  scon_bank_if.slave        bus,
  input  logic [NCH-1:0]    tx_complete,
  input  logic [NCH-1:0]    rx_complete,
  input  logic [NCH-1:0]    rb8_receive,
  output logic [8*NCH-1:0]  scon,
  output logic [2*NCH-1:0]  mode,
  output logic [NCH-1:0]    ren,
  output logic [NCH-1:0]    tb8,
  output logic [NCH-1:0]    irq,
  output logic              irq_any,
  output logic [AW-1:0]     irq_id,
  output logic [NCH-1:0]    ovr
);

  localparam int unsigned SM0 = 7;
  localparam int unsigned SM1 = 6;
  localparam int unsigned SM2 = 5;
  localparam int unsigned REN = 4;
  localparam int unsigned TB8 = 3;
  localparam int unsigned RB8 = 2;
  localparam int unsigned TI  = 1;
  localparam int unsigned RI  = 0;

  logic [NCH-1:0][7:0] scon_q;
  logic [NCH-1:0][7:0] scon_d;
  logic [NCH-1:0]      wr_hit;
  logic [NCH-1:0]      rx_accept;
  logic [NCH-1:0]      ovr_hit;
  logic [NCH-1:0]      irq_d;
  logic [AW-1:0]       irq_id_d;
  logic [7:0]          rd_sel;

  // Per-channel merge: CPU write first, then hardware sets; acceptance uses the pre-write register.
  always_comb begin
    scon_d    = scon_q;
    wr_hit    = '0;
    rx_accept = '0;
    ovr_hit   = '0;
    irq_d     = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      wr_hit[i]    = bus.wr_en && (bus.wr_addr == AW'(i));
      rx_accept[i] = rx_complete[i] && scon_q[i][REN] &&
                     (!scon_q[i][SM0] || !scon_q[i][SM2] || rb8_receive[i]);
      if (wr_hit[i]) scon_d[i] = bus.wr_data;
      if (tx_complete[i]) scon_d[i][TI] = 1'b1;
      if (rx_accept[i]) begin
        scon_d[i][RI] = 1'b1;
        if (scon_q[i][SM0] || scon_q[i][SM1]) scon_d[i][RB8] = rb8_receive[i];
      end
      ovr_hit[i] = rx_accept[i] && scon_q[i][RI] && !(wr_hit[i] && !bus.wr_data[RI]);
      irq_d[i]   = scon_d[i][TI] | scon_d[i][RI];
    end
  end

  // Fixed priority encoder, channel 0 wins.
  always_comb begin
    irq_id_d = '0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (irq_d[i]) irq_id_d = AW'(i);
    end
  end

  always_comb begin
    rd_sel = 8'h00;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (bus.rd_addr == AW'(i)) rd_sel = scon_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      scon_q      <= {NCH{RST_SCON}};
      irq         <= '0;
      irq_any     <= 1'b0;
      irq_id      <= '0;
      bus.rd_data <= 8'h00;
    end else begin
      scon_q      <= scon_d;
      irq         <= irq_d;
      irq_any     <= |irq_d;
      irq_id      <= irq_id_d;
      bus.rd_data <= rd_sel;
    end
  end

`ifdef SCON_OVERRUN_EN
  // Sticky overrun; a new overrun in the same cycle beats the clear-on-write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ovr <= '0;
    end else begin
      ovr <= ovr_hit | (ovr & ~wr_hit);
    end
  end
`else
  assign ovr = '0;
`endif

  always_comb begin
    scon = scon_q;
    mode = '0;
    ren  = '0;
    tb8  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      mode[2*i +: 2] = {scon_q[i][SM0], scon_q[i][SM1]};
      ren[i]         = scon_q[i][REN];
      tb8[i]         = scon_q[i][TB8];
    end
  end

endmodule

// File: tb/tb_scon_bank.sv
// Scoreboard testbench for scon_bank: stimulus pushes expected post-edge state
// from a reference model; an independent monitor pops and compares each cycle.
module tb_scon_bank;
  localparam int unsigned NCH = 4;
  localparam int unsigned AW  = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [NCH-1:0]   tx_complete, rx_complete, rb8_receive;
  logic [8*NCH-1:0] scon;
  logic [2*NCH-1:0] mode;
  logic [NCH-1:0]   ren, tb8, irq, ovr;
  logic             irq_any;
  logic [AW-1:0]    irq_id;

  scon_bank_if #(.AW(AW)) bus ();

  scon_bank #(.NCH(NCH), .AW(AW), .RST_SCON(8'h00)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .tx_complete(tx_complete), .rx_complete(rx_complete), .rb8_receive(rb8_receive),
    .scon(scon), .mode(mode), .ren(ren), .tb8(tb8), .irq(irq),
    .irq_any(irq_any), .irq_id(irq_id), .ovr(ovr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8*NCH-1:0] scon;
    logic [7:0]       rd;
    logic [NCH-1:0]   irq;
    logic             any;
    logic [AW-1:0]    id;
    logic [NCH-1:0]   ovr;
    logic [NCH-1:0]   ren;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  m_scon[NCH];
  logic        m_ovr[NCH];
  int          checks = 0;
  int          errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endfunction

  // One clock of stimulus; the model computes the state the DUT must show after the next edge.
  task automatic step(input logic rst_n, input logic we, input logic [AW-1:0] wa,
                      input logic [7:0] wd, input logic [AW-1:0] ra,
                      input logic [NCH-1:0] tx, input logic [NCH-1:0] rx,
                      input logic [NCH-1:0] rb8);
    exp_t       e;
    logic [7:0] old, val;
    logic       written, accept;
    int         first;
    @(negedge clk);
    reset = rst_n; bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd; bus.rd_addr = ra;
    tx_complete = tx; rx_complete = rx; rb8_receive = rb8;
    e.rd = (int'(ra) < NCH) ? m_scon[ra] : 8'h00;
    if (!rst_n) begin
      e.rd = 8'h00;
      for (int c = 0; c < NCH; c++) begin m_scon[c] = 8'h00; m_ovr[c] = 1'b0; end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        old     = m_scon[c];
        written = we && (int'(wa) == c);
        val     = written ? wd : old;
        // REN gate, then SM2 filter applies only in modes 2 and 3
        accept  = rx[c] && old[4];
        if (accept && old[7:6] >= 2'd2 && old[5] && !rb8[c]) accept = 1'b0;
        if (tx[c]) val[1] = 1'b1;
        if (accept) begin
          val[0] = 1'b1;
          if (old[7:6] != 2'd0) val[2] = rb8[c];
        end
        if (accept && old[0] && !(written && !wd[0])) m_ovr[c] = 1'b1;
        else if (written) m_ovr[c] = 1'b0;
        m_scon[c] = val;
      end
    end
    first = -1;
    for (int c = 0; c < NCH; c++) begin
      e.scon[8*c +: 8] = m_scon[c];
      e.irq[c]         = m_scon[c][1] | m_scon[c][0];
      e.ren[c]         = m_scon[c][4];
`ifdef SCON_OVERRUN_EN
      e.ovr[c]         = m_ovr[c];
`else
      e.ovr[c]         = 1'b0;
`endif
      if (e.irq[c] && first < 0) first = c;
    end
    e.any = (first >= 0);
    e.id  = (first >= 0) ? AW'(first) : '0;
    q.push_back(e);
  endtask

  task automatic wr(input logic [AW-1:0] ch, input logic [7:0] d);
    step(1'b1, 1'b1, ch, d, ch, '0, '0, '0);
  endtask

  task automatic ev(input logic [NCH-1:0] tx, input logic [NCH-1:0] rx, input logic [NCH-1:0] rb8);
    step(1'b1, 1'b0, '0, 8'h00, '0, tx, rx, rb8);
  endtask

  task automatic settle;
    @(posedge clk); #2;
  endtask

  // Monitor: every edge produces a full output set, compared against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("scon", 32'(scon), 32'(e.scon));
        chk("rd_data", 32'(bus.rd_data), 32'(e.rd));
        chk("irq", 32'(irq), 32'(e.irq));
        chk("irq_any", 32'(irq_any), 32'(e.any));
        chk("irq_id", 32'(irq_id), 32'(e.id));
        chk("ovr", 32'(ovr), 32'(e.ovr));
        chk("ren", 32'(ren), 32'(e.ren));
      end
    end
  end

  initial begin
    reset = 1'b0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
    tx_complete = '0; rx_complete = '0; rb8_receive = '0;
    for (int c = 0; c < NCH; c++) begin m_scon[c] = 8'h00; m_ovr[c] = 1'b0; end

    // Reset beats a write and all events in the same cycle
    step(1'b0, 1'b1, 2'd1, 8'hFF, 2'd1, '1, '1, '1);
    settle();
    chk("reset_scon", 32'(scon), 32'h0);
    chk("reset_irq_any", 32'(irq_any), 32'h0);
    chk("reset_rd", 32'(bus.rd_data), 32'h0);
    wr(2'd2, 8'h50);
    settle();
    chk("wr_ch2", 32'(scon[23:16]), 32'h50);
    chk("wr_mode2", 32'(mode[5:4]), 32'h1);
    chk("wr_ren2", 32'(ren[2]), 32'h1);

    // Mode 1 receive, then REN=0 ignores the frame
    wr(2'd1, 8'h50);
    ev(4'b0010, 4'b0000, 4'b0000);
    wr(2'd1, 8'h50);
    ev(4'b0000, 4'b0010, 4'b0010);
    settle();
    chk("m1_rx", 32'(scon[15:8]), 32'h55);
    chk("m1_irq", 32'(irq), 32'b0010);
    chk("m1_id", 32'(irq_id), 32'h1);
    wr(2'd1, 8'h40);
    ev(4'b0000, 4'b0010, 4'b0010);
    settle();
    chk("ren0_rx", 32'(scon[15:8]), 32'h40);

    // SM2 address filter
    wr(2'd0, 8'hF0);
    ev(4'b0000, 4'b0001, 4'b0000);
    settle();
    chk("sm2_drop", 32'(scon[7:0]), 32'hF0);
    ev(4'b0000, 4'b0001, 4'b0001);
    settle();
    chk("sm2_accept", 32'(scon[7:0]), 32'hF5);

    // Write colliding with TX and RX on one channel
    wr(2'd3, 8'h51);
    step(1'b1, 1'b1, 2'd3, 8'h50, 2'd3, 4'b1000, 4'b1000, 4'b0000);
    settle();
    chk("collision", 32'(scon[31:24]), 32'h53);
    chk("collision_rd_old", 32'(bus.rd_data), 32'h51);

    // Priority encoder
    wr(2'd0, 8'h00); wr(2'd2, 8'h00); wr(2'd3, 8'h00); wr(2'd1, 8'h00);
    ev(4'b1010, 4'b0000, 4'b0000);
    settle();
    chk("prio_13", 32'(irq_id), 32'h1);
    wr(2'd1, 8'h00);
    settle();
    chk("prio_3", 32'(irq_id), 32'h3);
    wr(2'd3, 8'h00);
    settle();
    chk("prio_none_any", 32'(irq_any), 32'h0);
    chk("prio_none_id", 32'(irq_id), 32'h0);

    // Overrun on a second accepted frame; cleared by a write
    wr(2'd0, 8'h10);
    ev(4'b0000, 4'b0001, 4'b0000);
    ev(4'b0000, 4'b0001, 4'b0000);
    settle();
`ifdef SCON_OVERRUN_EN
    chk("ovr_set", 32'(ovr[0]), 32'h1);
`else
    chk("ovr_off", 32'(ovr[0]), 32'h0);
`endif
    wr(2'd0, 8'h10);
    settle();
    chk("ovr_clr", 32'(ovr[0]), 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 59) != 0), ($urandom_range(0, 2) == 0),
           AW'($urandom), 8'($urandom), AW'($urandom),
           NCH'($urandom & $urandom), NCH'($urandom & $urandom), NCH'($urandom));
    end
    step(1'b1, 1'b0, '0, 8'h00, '0, '0, '0, '0);

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
